// File: rtl/uart_link_if.sv
// Ready/valid word channels between uart_link and its host: TX words in, RX words out.
interface uart_link_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/uart_link.sv
// Full-duplex UART with TX/RX FIFOs and mid-bit sampling receiver.
// Define UART_LINK_PARITY_EN to add an even-parity bit to every frame.
module uart_link #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  uart_link_if.slave io_bus,
  output logic       o_tx,
  input  logic       i_rx,
  output logic       o_tx_busy,
  output logic       o_frame_err,
  output logic       o_rx_overrun,
  output logic       o_parity_err
);
  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned BitW = $clog2(DATA_W);
  localparam logic [CntW-1:0] DivLast  = CntW'(DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(DIV / 2 - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWait} state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] r_txf_mem [FIFO_DEPTH];
  logic [AW:0]       r_txf_wr, r_txf_rd;
  logic              w_txf_empty, w_txf_full, w_txf_push, w_txf_pop;
  logic [DATA_W-1:0] w_txf_head;

  assign w_txf_empty     = (r_txf_wr == r_txf_rd);
  assign w_txf_full      = (r_txf_wr[AW] != r_txf_rd[AW]) &&
                           (r_txf_wr[AW-1:0] == r_txf_rd[AW-1:0]);
  assign w_txf_push      = io_bus.tx_valid & ~w_txf_full;
  assign w_txf_head      = r_txf_mem[r_txf_rd[AW-1:0]];
  assign io_bus.tx_ready = ~w_txf_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_txf_wr <= '0;
      r_txf_rd <= '0;
    end else begin
      if (w_txf_push) r_txf_wr <= r_txf_wr + (AW+1)'(1);
      if (w_txf_pop)  r_txf_rd <= r_txf_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_txf_push) r_txf_mem[r_txf_wr[AW-1:0]] <= io_bus.tx_data;
  end

  // ---------------- TX FSM ----------------
  state_e            r_tx_state, w_tx_state_d;
  logic [CntW-1:0]   r_tx_cnt, w_tx_cnt_d;
  logic [BitW-1:0]   r_tx_bit, w_tx_bit_d;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_d;
  logic              w_tx_tick, w_tx_load;
`ifdef UART_LINK_PARITY_EN
  logic              r_tx_par, w_tx_par_d;
`endif

  assign w_tx_tick = (r_tx_cnt == DivLast);

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_cnt_d   = r_tx_cnt;
    w_tx_bit_d   = r_tx_bit;
    w_tx_shift_d = r_tx_shift;
    w_tx_load    = 1'b0;
    w_txf_pop    = 1'b0;
`ifdef UART_LINK_PARITY_EN
    w_tx_par_d   = r_tx_par;
`endif
    if (r_tx_state != StIdle) w_tx_cnt_d = w_tx_tick ? '0 : r_tx_cnt + CntW'(1);
    case (r_tx_state)
      StIdle:  w_tx_load = ~w_txf_empty;
      StStart: if (w_tx_tick) begin
        w_tx_state_d = StData;
        w_tx_bit_d   = '0;
      end
      StData: if (w_tx_tick) begin
        w_tx_shift_d = {1'b0, r_tx_shift[DATA_W-1:1]};
        w_tx_bit_d   = r_tx_bit + BitW'(1);
`ifdef UART_LINK_PARITY_EN
        if (r_tx_bit == BitLast) w_tx_state_d = StParity;
`else
        if (r_tx_bit == BitLast) w_tx_state_d = StStop;
`endif
      end
`ifdef UART_LINK_PARITY_EN
      StParity: if (w_tx_tick) w_tx_state_d = StStop;
`endif
      StStop: if (w_tx_tick) begin
        w_tx_state_d = StIdle;
        w_tx_load    = ~w_txf_empty;
      end
      default: w_tx_state_d = StIdle;
    endcase
    // Loading in StStop chains frames with no idle gap.
    if (w_tx_load) begin
      w_txf_pop    = 1'b1;
      w_tx_shift_d = w_txf_head;
      w_tx_cnt_d   = '0;
      w_tx_state_d = StStart;
`ifdef UART_LINK_PARITY_EN
      w_tx_par_d   = ^w_txf_head;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state <= StIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
`ifdef UART_LINK_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_cnt   <= w_tx_cnt_d;
      r_tx_bit   <= w_tx_bit_d;
      r_tx_shift <= w_tx_shift_d;
`ifdef UART_LINK_PARITY_EN
      r_tx_par   <= w_tx_par_d;
`endif
    end
  end

  // Decoded from state so reset forces the line high without waiting for a clock.
  always_comb begin
    o_tx = 1'b1;
    case (r_tx_state)
      StStart:  o_tx = 1'b0;
      StData:   o_tx = r_tx_shift[0];
`ifdef UART_LINK_PARITY_EN
      StParity: o_tx = r_tx_par;
`endif
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_tx_busy = (r_tx_state != StIdle) | ~w_txf_empty;

  // ---------------- RX FSM ----------------
  logic              r_rx_s1, r_rx_s2, r_rx_prev;
  state_e            r_rx_state, w_rx_state_d;
  logic [CntW-1:0]   r_rx_cnt, w_rx_cnt_d;
  logic [BitW-1:0]   r_rx_bit, w_rx_bit_d;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_d;
  logic              r_rx_push, w_rx_push_d;
  logic              r_frame_err, w_frame_err_d;
  logic              w_rx_tick, w_par_ok;
`ifdef UART_LINK_PARITY_EN
  logic              r_rx_par, w_rx_par_d;
  logic              r_parity_err, w_parity_err_d;
  assign w_par_ok = (r_rx_par == ^r_rx_shift);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_rx_tick = (r_rx_cnt == DivLast);

  always_comb begin
    w_rx_state_d  = r_rx_state;
    w_rx_cnt_d    = r_rx_cnt;
    w_rx_bit_d    = r_rx_bit;
    w_rx_shift_d  = r_rx_shift;
    w_rx_push_d   = 1'b0;
    w_frame_err_d = 1'b0;
`ifdef UART_LINK_PARITY_EN
    w_rx_par_d     = r_rx_par;
    w_parity_err_d = 1'b0;
`endif
    if (r_rx_state != StIdle && r_rx_state != StWait) begin
      w_rx_cnt_d = w_rx_tick ? '0 : r_rx_cnt + CntW'(1);
    end
    case (r_rx_state)
      // r_rx_prev resets low, so a falling edge needs one real high cycle first.
      StIdle: if (r_rx_prev & ~r_rx_s2) begin
        w_rx_state_d = StStart;
        w_rx_cnt_d   = '0;
      end
      StStart: if (r_rx_cnt == HalfLast) begin
        w_rx_cnt_d   = '0;
        w_rx_bit_d   = '0;
        w_rx_state_d = r_rx_s2 ? StIdle : StData;
      end
      StData: if (w_rx_tick) begin
        w_rx_shift_d = {r_rx_s2, r_rx_shift[DATA_W-1:1]};
        w_rx_bit_d   = r_rx_bit + BitW'(1);
`ifdef UART_LINK_PARITY_EN
        if (r_rx_bit == BitLast) w_rx_state_d = StParity;
`else
        if (r_rx_bit == BitLast) w_rx_state_d = StStop;
`endif
      end
`ifdef UART_LINK_PARITY_EN
      StParity: if (w_rx_tick) begin
        w_rx_par_d   = r_rx_s2;
        w_rx_state_d = StStop;
      end
`endif
      StStop: if (w_rx_tick) begin
        if (r_rx_s2) begin
          w_rx_state_d = StIdle;
          w_rx_push_d  = w_par_ok;
`ifdef UART_LINK_PARITY_EN
          w_parity_err_d = ~w_par_ok;
`endif
        end else begin
          w_rx_state_d  = StWait;
          w_frame_err_d = 1'b1;
        end
      end
      StWait: if (r_rx_s2) w_rx_state_d = StIdle;
      default: w_rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b0;
      r_rx_state  <= StIdle;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_push   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_LINK_PARITY_EN
      r_rx_par     <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_s1     <= i_rx;
      r_rx_s2     <= r_rx_s1;
      r_rx_prev   <= r_rx_s2;
      r_rx_state  <= w_rx_state_d;
      r_rx_cnt    <= w_rx_cnt_d;
      r_rx_bit    <= w_rx_bit_d;
      r_rx_shift  <= w_rx_shift_d;
      r_rx_push   <= w_rx_push_d;
      r_frame_err <= w_frame_err_d;
`ifdef UART_LINK_PARITY_EN
      r_rx_par     <= w_rx_par_d;
      r_parity_err <= w_parity_err_d;
`endif
    end
  end

  assign o_frame_err = r_frame_err;
`ifdef UART_LINK_PARITY_EN
  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0] r_rxf_mem [FIFO_DEPTH];
  logic [AW:0]       r_rxf_wr, r_rxf_rd;
  logic              w_rxf_empty, w_rxf_full, w_rxf_push, w_rxf_pop;

  assign w_rxf_empty     = (r_rxf_wr == r_rxf_rd);
  assign w_rxf_full      = (r_rxf_wr[AW] != r_rxf_rd[AW]) &&
                           (r_rxf_wr[AW-1:0] == r_rxf_rd[AW-1:0]);
  assign w_rxf_pop       = ~w_rxf_empty & io_bus.rx_ready;
  // A pop frees the slot being written, so a full FIFO still accepts a word then.
  assign w_rxf_push      = r_rx_push & (~w_rxf_full | w_rxf_pop);
  assign o_rx_overrun    = r_rx_push & w_rxf_full & ~w_rxf_pop;
  assign io_bus.rx_valid = ~w_rxf_empty;
  assign io_bus.rx_data  = r_rxf_mem[r_rxf_rd[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rxf_wr <= '0;
      r_rxf_rd <= '0;
    end else begin
      if (w_rxf_push) r_rxf_wr <= r_rxf_wr + (AW+1)'(1);
      if (w_rxf_pop)  r_rxf_rd <= r_rxf_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rxf_push) r_rxf_mem[r_rxf_wr[AW-1:0]] <= r_rx_shift;
  end
endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link at DIV=10 with 4-entry FIFOs; covers parity when the macro is set.
`timescale 1ns/1ps
module tb_uart_link;
  localparam int DIV = 10;
`ifdef UART_LINK_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  localparam int FrameCyc = DIV * NBits;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_link_if #(.DATA_W(8)) bus ();
  logic tx, rx, tx_busy, frame_err, rx_overrun, parity_err;
  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;
  assign rx = loop_en ? tx : rx_drv;

  uart_link #(
    .CLK_HZ    (100000000),
    .BAUD      (10000000),
    .DATA_W    (8),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .io_bus      (bus),
    .o_tx        (tx),
    .i_rx        (rx),
    .o_tx_busy   (tx_busy),
    .o_frame_err (frame_err),
    .o_rx_overrun(rx_overrun),
    .o_parity_err(parity_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int pe_cnt  = 0;
  int ov_cnt  = 0;

  // Count cycles each error pulse is high.
  always @(posedge clk) begin
    if (frame_err === 1'b1)  fe_cnt++;
    if (parity_err === 1'b1) pe_cnt++;
    if (rx_overrun === 1'b1) ov_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    int guard = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: tx_ready=%b required 1", bus.tx_ready);
    end
    tick();
    bus.tx_valid = 1'b0;
  endtask

  task automatic pop();
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(DIV);
    end
`ifdef UART_LINK_PARITY_EN
    rx_drv = par;
    tick(DIV);
`else
    if (par === 1'bx) rx_drv = 1'b1;
`endif
    rx_drv = stop;
    tick(DIV);
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    tick(3);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
    n_tests++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b required 1", bus.tx_ready); end
    n_tests++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b required 0", bus.rx_valid); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b required 0", tx_busy); end
    n_tests++;
    if ({frame_err, rx_overrun, parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b required 000", {frame_err, rx_overrun, parity_err});
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_tx_frame();
`ifdef UART_LINK_PARITY_EN
    bit exp_bits [NBits] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    bit exp_bits [NBits] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    int cur = 0;
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_lat_n1: got %b required 1", tx); end
    n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy_n1: got %b required 1", tx_busy); end
    tick();
    n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL tx_lat_n2: got %b required 0", tx); end
    for (int k = 0; k < NBits; k++) begin
      tick(k * DIV + 5 - cur);
      cur = k * DIV + 5;
      n_tests++;
      if (tx !== exp_bits[k]) begin
        n_fail++; $display("FAIL tx_bit%0d: got %b required %b", k, tx, exp_bits[k]);
      end
    end
    n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy_stop: got %b required 1", tx_busy); end
    tick(5);
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL tx_busy_end: got %b required 0", tx_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h3C};
    int fe0 = fe_cnt;
    int pe0 = pe_cnt;
    int ov0 = ov_cnt;
    loop_en = 1'b1;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tx_data = words[i];
      tick();
    end
    bus.tx_valid = 1'b0;
    for (int f = 1; f < 3; f++) begin
      tick((f == 1) ? FrameCyc - 2 : FrameCyc - 1);
      n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_stop%0d: got %b required 1", f, tx); end
      tick();
      n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start%0d: got %b required 0", f, tx); end
    end
    tick(FrameCyc + 30);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== words[i]) begin
        n_fail++; $display("FAIL b2b_rx%0d: got valid=%b data=%h required valid=1 data=%h",
                           i, bus.rx_valid, bus.rx_data, words[i]);
      end
      pop();
    end
    n_tests++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b required 0", bus.rx_valid); end
    n_tests++;
    if (fe_cnt != fe0 || pe_cnt != pe0 || ov_cnt != ov0) begin
      n_fail++; $display("FAIL b2b_errors: got fe=%0d pe=%0d ov=%0d required 0 0 0",
                         fe_cnt - fe0, pe_cnt - pe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int ov0 = ov_cnt;
    loop_en = 1'b1;
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(words[i]);
    push(8'h55);
    n_tests++; if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL txf_full: got %b required 0", bus.tx_ready); end
    // Offered while full: must be ignored.
    bus.tx_data  = 8'hEE;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    tick(6 * FrameCyc + 20);
    n_tests++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL ovr_count: got %0d required 1", ov_cnt - ov0); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL ovr_tx_idle: got %b required 0", tx_busy); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== words[i]) begin
        n_fail++; $display("FAIL ovr_rx%0d: got valid=%b data=%h required valid=1 data=%h",
                           i, bus.rx_valid, bus.rx_data, words[i]);
      end
      pop();
    end
    n_tests++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty: got %b required 0", bus.rx_valid); end
  endtask

  task automatic test_frame_err();
    int fe0;
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    tick(5);
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    tick(20);
    n_tests++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles required 1", fe_cnt - fe0); end
    n_tests++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_rx_valid: got %b required 0", bus.rx_valid); end
    rx_drv = 1'b0;
    tick(3);
    rx_drv = 1'b1;
    tick(40);
    n_tests++;
    if (fe_cnt - fe0 != 1 || bus.rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch: got fe=%0d valid=%b required fe=1 valid=0", fe_cnt - fe0, bus.rx_valid);
    end
    send_frame(8'h96, 1'b0, 1'b1);
    tick(10);
    n_tests++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h96) begin
      n_fail++; $display("FAIL post_glitch_rx: got valid=%b data=%h required valid=1 data=96",
                         bus.rx_valid, bus.rx_data);
    end
    pop();
  endtask

`ifdef UART_LINK_PARITY_EN
  task automatic test_parity();
    int pe0;
    loop_en = 1'b1;
    push(8'h07);
    tick(96);
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL par_bit: got %b required 1", tx); end
    tick(FrameCyc + 20);
    n_tests++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h07) begin
      n_fail++; $display("FAIL par_loop_rx: got valid=%b data=%h required valid=1 data=07",
                         bus.rx_valid, bus.rx_data);
    end
    pop();
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    tick(2);
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    tick(10);
    n_tests++; if (pe_cnt - pe0 != 1) begin n_fail++; $display("FAIL par_err_pulse: got %0d required 1", pe_cnt - pe0); end
    n_tests++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL par_drop: got %b required 0", bus.rx_valid); end
  endtask
`endif

  task automatic test_reset_mid();
    int fe0;
    loop_en = 1'b1;
    push(8'hC3);
    tick(1 + DIV + 35);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b required 1", tx); end
    n_tests++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b required 1", bus.tx_ready); end
    n_tests++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rx_valid: got %b required 0", bus.rx_valid); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", tx_busy); end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    fe0 = fe_cnt;
    push(8'h5A);
    tick();
    n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_next_start: got %b required 0", tx); end
    tick(FrameCyc + 20);
    n_tests++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A || fe_cnt != fe0) begin
      n_fail++; $display("FAIL rst_next_rx: got valid=%b data=%h fe=%0d required valid=1 data=5a fe=0",
                         bus.rx_valid, bus.rx_data, fe_cnt - fe0);
    end
    pop();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_overrun();
    test_frame_err();
`ifdef UART_LINK_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
